pipe_stage_elastic: RTL and testbench

PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_stage_elastic.sv | 101 ++++++++++
 tb/tb_pipe_stage_elastic.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the decode/execute pipeline stage: payload layout and flush sources.
package pipe_pkg;

    // Payload is five 32-bit fields packed MSB-first: pc, rs1, rs2, imm, instr.
    localparam int FIELD_W   = 32;
    localparam int PAYLOAD_W = 5 * FIELD_W;

    localparam int OFF_INSTR = 0;
    localparam int OFF_IMM   = 32;
    localparam int OFF_RS2   = 64;
    localparam int OFF_RS1   = 96;
    localparam int OFF_PC    = 128;

    // Flush source bit positions within flush_src / flush_cause.
    localparam int FLUSH_SRC_N = 5;
    localparam int FL_BRANCH   = 0;
    localparam int FL_LOADUSE  = 1;
    localparam int FL_WFI      = 2;
    localparam int FL_INTR     = 3;
    localparam int FL_INTR_END = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Count up on inc, hold once every bit is set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline stage (main + skid) with freeze, multi-source flush
// and a saturating flush counter.
//
// Handshake: a transfer happens on a cycle where valid and ready are both high at
// the rising edge. in_ready depends only on registered state and freeze, never on
// in_valid; out_valid/out_data come straight from flops. A frozen stage moves
// nothing, so an output transfer additionally requires !freeze.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W  = PAYLOAD_W,
    parameter int FLUSH_N = FLUSH_SRC_N,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic [FLUSH_N-1:0] flush_src,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready,
    output logic [FLUSH_N-1:0] flush_cause,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic               skid_valid;
    logic [DATA_W-1:0]  skid_data;
    logic [FLUSH_N-1:0] pend_cause;

    logic in_xfer;
    logic out_xfer;
    logic flush_eff;

    // Ready only while the skid slot is free; freeze blocks every transfer.
    always_comb begin
        in_ready  = !skid_valid && !freeze;
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready && !freeze;
        flush_eff = !freeze && ((|flush_src) || (|pend_cause));
    end

    // Storage update: reset > freeze > flush > normal flow. The main entry is
    // out_valid/out_data itself, and its data is zeroed whenever it goes empty
    // so a bubble reads as an all-zero instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            pend_cause  <= '0;
            flush_cause <= '0;
        end else if (freeze) begin
            // Remember flushes seen while frozen; apply them on the first free cycle.
            pend_cause <= pend_cause | flush_src;
        end else if (flush_eff) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            flush_cause <= flush_src | pend_cause;
            pend_cause  <= '0;
        end else if (out_xfer) begin
            // in_ready is low when skid is full, so skid and input never compete.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else if (in_xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end
        end else if (in_xfer) begin
            if (out_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end else begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end
        end
    end

    // One count per applied flush; freeze is already folded into flush_eff.
    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (flush_eff),
        .value(flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenario tasks plus a
// negedge scoreboard that models the two-entry queue, pending flushes and counter.
module tb_pipe_stage_elastic;

    localparam int DATA_W  = 160;
    localparam int FLUSH_N = 5;
    localparam int CNT_W   = 16;

    logic               clk;
    logic               rst;
    logic               freeze;
    logic [FLUSH_N-1:0] flush_src;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_ready;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_ready;
    logic [FLUSH_N-1:0] flush_cause;
    logic [CNT_W-1:0]   flush_cnt;

    int vectors;
    int miscompares;

    // Scoreboard / reference model state
    logic [DATA_W-1:0]  exp_q[$];
    logic [FLUSH_N-1:0] pend_m;
    logic [FLUSH_N-1:0] cause_m;
    logic [CNT_W-1:0]   cnt_m;
    logic               mon_en;

    pipe_stage_elastic #(
        .DATA_W (DATA_W),
        .FLUSH_N(FLUSH_N),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .flush_src  (flush_src),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush_cause(flush_cause),
        .flush_cnt  (flush_cnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: at negedge, decide what the coming posedge must do.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            pend_m  = '0;
            cause_m = '0;
            cnt_m   = '0;
        end else if (mon_en) begin
            logic exp_ready;
            exp_ready = (exp_q.size() < 2) && !freeze;
            vectors++;
            if (in_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL mon_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_ready);
            end
            vectors++;
            if (out_valid !== (exp_q.size() != 0)) begin
                miscompares++;
                $display("FAIL mon_out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() == 0) begin
                vectors++;
                if (out_data !== '0) begin
                    miscompares++;
                    $display("FAIL mon_bubble_zero t=%0t got=%h exp=0", $time, out_data);
                end
            end
            if (freeze) begin
                pend_m = pend_m | flush_src;
            end else if ((|flush_src) || (|pend_m)) begin
                exp_q.delete();
                cause_m = flush_src | pend_m;
                pend_m  = '0;
                if (cnt_m != {CNT_W{1'b1}}) cnt_m = cnt_m + 1'b1;
            end else begin
                if (exp_q.size() != 0 && out_ready) begin
                    vectors++;
                    if (out_data !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL mon_out_data t=%0t got=%h exp=%h", $time, out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                if (in_valid && exp_ready) exp_q.push_back(in_data);
            end
        end
    end

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic idle_inputs();
        freeze    = 1'b0;
        flush_src = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_out got=%b/%h exp=0/0", out_valid, out_data);
        end
        vectors++;
        if (flush_cnt !== '0 || flush_cause !== '0) begin
            miscompares++;
            $display("FAIL reset_flush got=%h/%b exp=0/0", flush_cnt, flush_cause);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] a[4];
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a[i]     = rand_data();
            in_valid = 1'b1;
            in_data  = a[i];
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== a[i]) begin
                miscompares++;
                $display("FAIL stream_A%0d got=%b/%h exp=1/%h", i + 1, out_valid, out_data, a[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_skid();
        logic [DATA_W-1:0] a1, a2;
        a1 = rand_data();
        a2 = rand_data();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = a1;
        tick();
        out_ready = 1'b0;
        in_data   = a2;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || out_data !== a1) begin
            miscompares++;
            $display("FAIL skid_hold got=%b/%h exp=0/%h", in_ready, out_data, a1);
        end
        tick();
        vectors++;
        if (out_data !== a1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL skid_stall got=%b/%h exp=0/%h", in_ready, out_data, a1);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== a2 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL skid_release got=%b/%b/%h exp=1/1/%h", out_valid, in_ready, out_data, a2);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL skid_empty got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_data();
        tick();
        in_data = rand_data();
        tick();
        in_data   = rand_data();
        flush_src = 5'b00001;
        tick();
        flush_src = '0;
        in_valid  = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL flush_out got=%b/%h exp=0/0", out_valid, out_data);
        end
        vectors++;
        if (flush_cause !== 5'b00001 || flush_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL flush_cause_cnt got=%b/%0d exp=00001/1", flush_cause, flush_cnt);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_dropped got=%b/%b exp=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_freeze_flush();
        logic [DATA_W-1:0] c1;
        c1        = rand_data();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = c1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        freeze    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush_src = (i == 1) ? 5'b01000 : 5'b00000;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== c1 || flush_cause !== 5'b00001 || flush_cnt !== 16'd1) begin
                miscompares++;
                $display("FAIL freeze_hold%0d got=%b/%h/%b/%0d exp=1/%h/00001/1",
                         i, out_valid, out_data, flush_cause, flush_cnt, c1);
            end
        end
        freeze    = 1'b0;
        flush_src = '0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || flush_cause !== 5'b01000 || flush_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL freeze_flush_apply got=%b/%b/%0d exp=0/01000/2", out_valid, flush_cause, flush_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rand_data();
            out_ready = ($urandom_range(0, 3) != 0);
            freeze    = ($urandom_range(0, 9) == 0);
            flush_src = ($urandom_range(0, 11) == 0) ? FLUSH_N'($urandom_range(1, 31)) : '0;
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        vectors++;
        if (flush_cnt !== cnt_m || flush_cause !== cause_m) begin
            miscompares++;
            $display("FAIL random_flush_state got=%0d/%b exp=%0d/%b", flush_cnt, flush_cause, cnt_m, cause_m);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        flush_src = 5'b00010;
        for (int i = 0; i < 65534; i++) tick();
        vectors++;
        if (flush_cnt !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL sat_preload got=%h exp=fffe", flush_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (flush_cnt !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL sat_flush%0d got=%h exp=ffff", i, flush_cnt);
            end
        end
        flush_src = '0;
        tick();
    endtask

    task automatic test_reset_override();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_data();
        tick();
        in_data = rand_data();
        tick();
        in_valid  = 1'b0;
        freeze    = 1'b1;
        flush_src = 5'b10000;
        rst       = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0 || flush_cnt !== '0 || flush_cause !== '0) begin
            miscompares++;
            $display("FAIL rst_override got=%b/%h/%0d/%b exp=0/0/0/0", out_valid, out_data, flush_cnt, flush_cause);
        end
        rst       = 1'b1;
        freeze    = 1'b0;
        flush_src = '0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_release_ready got=%b exp=1", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || flush_cnt !== '0) begin
            miscompares++;
            $display("FAIL rst_no_pending got=%b/%0d exp=0/0", out_valid, flush_cnt);
        end
    endtask

    // Test sequence and final report
    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        rst         = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_skid();
        test_flush_full();
        test_freeze_flush();
        test_back_to_back();
        test_saturate();
        test_reset_override();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
